// File: rtl/param_updown_counter.sv
// Up/down counter with runtime limit, saturate-or-wrap boundary mode and sticky flags.
// Latency: count, wrap_pulse and sticky flags are registered (1 cycle); at_max/at_min are combinational.
// Backpressure: none; a step is taken on every rising edge where en is high and load is low.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse,
  output logic             ovf_sticky,
  output logic             udf_sticky
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovf_set, udf_set;

  // Next-state selection: load beats a step, a step beats hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (load) begin
      // Loads are clamped into the legal range and never touch the flags.
      count_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (count_q > limit) begin
        // Limit was lowered under us: snap back into range quietly.
        count_d = limit;
      end else if (up) begin
        if (count_q == limit) begin
          ovf_set = 1'b1;
          if (!sat) begin
            count_d = ZERO;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == ZERO) begin
          udf_set = 1'b1;
          if (!sat) begin
            count_d = limit;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
    // A set event on the same edge as a clear keeps the flag up.
    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    udf_d = udf_set | (udf_q & ~clr_flags);
  end

  // State registers; reset wipes any pending pulse or flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_CNT;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign ovf_sticky = ovf_q;
  assign udf_sticky = udf_q;
  assign at_max     = (count_q == limit);
  assign at_min     = (count_q == ZERO);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter at WIDTH=4, RESET_VAL=3.
// Table of per-edge vectors with hand-computed results, plus a hand-written async-reset sequence.
// Outputs are sampled 1 time unit after the rising edge or mid-cycle for async checks.
module tb_param_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up, load, sat, clr_flags;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         at_max, at_min, wrap_pulse, ovf_sticky, udf_sticky;

  int checks = 0;
  int errors = 0;

  param_updown_counter #(.WIDTH(W), .RESET_VAL(3)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .sat(sat), .clr_flags(clr_flags),
    .count(count), .at_max(at_max), .at_min(at_min),
    .wrap_pulse(wrap_pulse), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         e;
    logic         u;
    logic [W-1:0] lim;
    logic         s;
    logic         clr;
    logic [W-1:0] c;
    logic         w;
    logic         o;
    logic         d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input int lv, input logic e, input logic u,
                     input int lim, input logic s, input logic clr,
                     input int c, input logic w, input logic o, input logic d);
    vec_t v;
    v.ld = ld; v.lv = W'(lv); v.e = e; v.u = u; v.lim = W'(lim); v.s = s; v.clr = clr;
    v.c = W'(c); v.w = w; v.o = o; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input logic w, input logic o,
                           input logic d, input int lim);
    check({tag, " count"}, int'(count), c);
    check({tag, " wrap_pulse"}, int'(wrap_pulse), int'(w));
    check({tag, " ovf_sticky"}, int'(ovf_sticky), int'(o));
    check({tag, " udf_sticky"}, int'(udf_sticky), int'(d));
    check({tag, " at_max"}, int'(at_max), int'(c == lim));
    check({tag, " at_min"}, int'(at_min), int'(c == 0));
  endtask

  initial begin
    // Load clamps to limit; lowering limit snaps count down without flags.
    add(1, 12, 1, 1, 9, 0, 0,   9, 0, 0, 0);
    add(0,  0, 1, 1, 5, 0, 0,   5, 0, 0, 0);
    add(0,  0, 0, 1, 5, 0, 0,   5, 0, 0, 0);
    // Full natural up-wrap, 17 edges from 0 at limit 15.
    add(1,  0, 0, 1, 15, 0, 0,  0, 0, 0, 0);
    for (int i = 1; i <= 17; i++)
      add(0, 0, 1, 1, 15, 0, 0, (i <= 15) ? i : i - 16, (i == 16), (i >= 16), 0);
    add(0,  0, 0, 1, 15, 0, 1,  1, 0, 0, 0);
    // Saturating up at limit 9 from 8.
    add(1,  8, 0, 1, 9, 1, 0,   8, 0, 0, 0);
    add(0,  0, 1, 1, 9, 1, 0,   9, 0, 0, 0);
    add(0,  0, 1, 1, 9, 1, 0,   9, 0, 1, 0);
    add(0,  0, 1, 1, 9, 1, 0,   9, 0, 1, 0);
    // Wrapping down at limit 9 from 1.
    add(1,  1, 0, 0, 9, 0, 1,   1, 0, 0, 0);
    add(0,  0, 1, 0, 9, 0, 0,   0, 0, 0, 0);
    add(0,  0, 1, 0, 9, 0, 0,   9, 1, 0, 1);
    add(0,  0, 0, 0, 9, 0, 0,   9, 0, 0, 1);
    add(0,  0, 1, 0, 9, 0, 0,   8, 0, 0, 1);
    // Saturating down at 0.
    add(1,  0, 0, 0, 9, 1, 1,   0, 0, 0, 0);
    add(0,  0, 1, 0, 9, 1, 0,   0, 0, 0, 1);
    // limit == 0: back-to-back wraps in both directions.
    add(1,  5, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    add(0,  0, 1, 1, 0, 0, 0,   0, 1, 1, 0);
    add(0,  0, 1, 0, 0, 0, 0,   0, 1, 1, 1);
    add(0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 1);
    // Clear coincident with a new up-wrap: set wins for ovf, udf clears.
    add(1, 15, 0, 1, 15, 0, 0,  15, 0, 1, 1);
    add(0,  0, 1, 1, 15, 0, 1,  0, 1, 1, 0);
    add(0,  0, 0, 1, 15, 0, 1,  0, 0, 0, 0);
    add(0,  0, 1, 0, 15, 0, 0,  15, 1, 0, 1);

    // Reset state.
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; sat = 1'b0; clr_flags = 1'b0;
    load_val = '0; limit = 4'd9;
    #12;
    check_all("reset", 3, 0, 0, 0, 9);
    rst = 1'b0; en = 1'b0;

    foreach (vecs[i]) begin
      load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].e; up = vecs[i].u;
      limit = vecs[i].lim; sat = vecs[i].s; clr_flags = vecs[i].clr;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), int'(vecs[i].c), vecs[i].w, vecs[i].o,
                vecs[i].d, int'(vecs[i].lim));
    end

    // Async reset at count 7 with an overflow wrap pending.
    load = 1'b1; load_val = 4'd7; limit = 4'd7; en = 1'b0; up = 1'b1; sat = 1'b1; clr_flags = 1'b1;
    @(posedge clk); #1;
    check_all("rseq load7", 7, 0, 0, 0, 7);
    load = 1'b0; clr_flags = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check_all("rseq sat7", 7, 0, 1, 0, 7);
    sat = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_all("rseq async", 3, 0, 0, 0, 7);
    @(posedge clk); #1;
    check_all("rseq held", 3, 0, 0, 0, 7);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_all("rseq first", 4, 0, 0, 0, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: count value after reset; SHALL be <= 2**WIDTH-1.
REQ-003 clk  input  1  clock; all state changes on rising edge except reset.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable; step taken only when high.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value loaded when load is high.
REQ-009 limit  input  WIDTH  upper bound; legal count range is 0..limit.
REQ-010 sat  input  1  boundary mode; 1 = saturate, 0 = wrap.
REQ-011 clr_flags  input  1  synchronous clear of sticky flags.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 at_max  output  1  combinational, high when count == limit.
REQ-014 at_min  output  1  combinational, high when count == 0.
REQ-015 wrap_pulse  output  1  registered, one-cycle pulse marking a wrap.
REQ-016 ovf_sticky  output  1  registered, sticky overflow flag.
REQ-017 udf_sticky  output  1  registered, sticky underflow flag.

Function
REQ-018 Per-edge priority SHALL be: load > en step > hold.
REQ-019 Load: count <= min(load_val, limit); no flag or pulse effect; en ignored that cycle.
REQ-020 Up step, count < limit: count <= count + 1.
REQ-021 Up step, count == limit: sat=1 -> count held; sat=0 -> count <= 0 and wrap_pulse high next cycle; ovf_sticky set in both modes.
REQ-022 Down step, 0 < count <= limit: count <= count - 1.
REQ-023 Down step, count == 0: sat=1 -> count held; sat=0 -> count <= limit and wrap_pulse high next cycle; udf_sticky set in both modes.
REQ-024 Step with count > limit (limit lowered at runtime): count <= limit in either direction; no flag set; no pulse.
REQ-025 limit == 0: count stays 0; up step sets ovf_sticky; down step sets udf_sticky; with sat=0, wrap_pulse pulses on each such step.
REQ-026 wrap_pulse SHALL be high exactly in the cycle after a wrapping edge (coincident with the new count) and low otherwise; back-to-back wraps give consecutive high cycles.
REQ-027 Arithmetic SHALL be modulo 2**WIDTH internally with no carry-out; limit = 2**WIDTH-1 gives full natural wrap.
REQ-028 clr_flags clears both sticky flags; on the same edge as a set event, set wins.
REQ-029 With en=0 and load=0, count and sticky flags hold and wrap_pulse is 0.

Reset
REQ-030 On rst high, immediately and independent of clk: count = RESET_VAL, wrap_pulse = 0, ovf_sticky = 0, udf_sticky = 0.
REQ-031 While rst is high, all inputs SHALL be ignored; the first step SHALL be on the first rising edge after rst falls.
REQ-032 Reset asserted mid-count or coincident with a wrap SHALL suppress the pending wrap_pulse and flag set.

Verification
REQ-033 WIDTH=4, limit=15, sat=0, up=1, en=1, 17 edges from 0 -> count 1..15, 0, 1; wrap_pulse high once, with count=0; ovf_sticky=1.
REQ-034 limit=9, sat=1, up=1 from 8, 3 edges -> count 9, 9, 9; at_max=1; ovf_sticky=1; wrap_pulse never high.
REQ-035 limit=9, sat=0, up=0 from 1, 2 edges -> count 0, then 9; wrap_pulse with count=9; udf_sticky=1.
REQ-036 load=1, en=1, load_val=12, limit=9 -> count=9, no flags; then lower limit to 5 with en=1 -> count=5 after one edge.
REQ-037 ovf_sticky=1, then clr_flags=1 on the same edge as a new up-wrap -> ovf_sticky stays 1; clr_flags alone next edge -> 0.
REQ-038 rst pulsed between clk edges mid-count at count=7 -> count=RESET_VAL immediately, flags 0, no wrap_pulse on the next edge.
